// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output start, a, b,
      input  busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, bout, ovf
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one difference/borrow cell with a registered borrow.
// Parallel result with unsigned borrow-out and signed overflow, start/done handshake.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_subtractor_if.slave  bus
);
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] rs_q, rs_d;
   logic             br_q, br_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             amsb_q, amsb_d;
   logic             bmsb_q, bmsb_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             d_bit;

   // Next-state, datapath and output logic
   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      rs_d    = rs_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      amsb_d  = amsb_q;
      bmsb_d  = bmsb_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      d_bit   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               sa_d    = bus.a;
               sb_d    = bus.b;
               amsb_d  = bus.a[WIDTH-1];
               bmsb_d  = bus.b[WIDTH-1];
               rs_d    = '0;
               br_d    = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            d_bit = sa_q[0] ^ sb_q[0] ^ br_q;
            br_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            rs_d  = {d_bit, rs_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               // Result is published from the values this edge produces.
               diff_d  = rs_d;
               bout_d  = br_d;
               ovf_d   = (amsb_q ^ bmsb_q) & (rs_d[WIDTH-1] ^ amsb_q);
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         rs_q    <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         amsb_q  <= 1'b0;
         bmsb_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         rs_q    <= rs_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         amsb_q  <= amsb_d;
         bmsb_q  <= bmsb_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.ovf  = ovf_q;
endmodule
